// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants and types for the forwarding / hazard controller.
package fwd_hazard_ctrl_pkg;

    // Bypass source select encodings
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;
    localparam logic [1:0] FWD_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_MWAIT = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-side bus of the forwarding / hazard controller.
// master: the pipeline (drives hazard inputs, consumes selects/holds).
// slave:  the controller.
interface fwd_hazard_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_use1;
    logic              ex_use2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_memread;
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_wen;
    logic              exmem_memread;
    logic [XLEN-1:0]   exmem_result;
    logic              mem_ready;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_wen;
    logic [XLEN-1:0]   memwb_value;

    logic [1:0]        fwd1_sel;
    logic [1:0]        fwd2_sel;
    logic [XLEN-1:0]   fwd1_data;
    logic [XLEN-1:0]   fwd2_data;
    logic              pc_hold;
    logic              ifid_hold;
    logic              idex_bubble;
    logic              pipe_freeze;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  fwd_cnt;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2,
        output ex_rs1, ex_rs2, ex_use1, ex_use2, ex_rd, ex_memread,
        output exmem_rd, exmem_wen, exmem_memread, exmem_result, mem_ready,
        output memwb_rd, memwb_wen, memwb_value,
        input  fwd1_sel, fwd2_sel, fwd1_data, fwd2_data,
        input  pc_hold, ifid_hold, idex_bubble, pipe_freeze,
        input  stall_cnt, fwd_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2,
        input  ex_rs1, ex_rs2, ex_use1, ex_use2, ex_rd, ex_memread,
        input  exmem_rd, exmem_wen, exmem_memread, exmem_result, mem_ready,
        input  memwb_rd, memwb_wen, memwb_value,
        output fwd1_sel, fwd2_sel, fwd1_data, fwd2_data,
        output pc_hold, ifid_hold, idex_bubble, pipe_freeze,
        output stall_cnt, fwd_cnt
    );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel_mux.sv
// Per-operand bypass selection: priority compare over the three bypass
// levels and the matching data mux. Purely combinational.
module fwd_sel_mux
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              use_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_wen_i,
    input  logic              exmem_memread_i,
    input  logic [XLEN-1:0]   exmem_result_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_wen_i,
    input  logic [XLEN-1:0]   memwb_value_i,
    input  logic              hold_en_i,
    input  logic [REG_AW-1:0] hold_rd_i,
    input  logic [XLEN-1:0]   hold_val_i,
    output logic [1:0]        sel_o,
    output logic [XLEN-1:0]   data_o
);

    logic hit_exmem;
    logic hit_memwb;
    logic hit_hold;

    // A load sitting in EX/MEM has no valid data yet, so it is not a
    // bypass source; the older levels are still considered.
    assign hit_exmem = use_i && (rs_i != '0) && exmem_wen_i && !exmem_memread_i
                       && (exmem_rd_i == rs_i);
    assign hit_memwb = use_i && (rs_i != '0) && memwb_wen_i && (memwb_rd_i == rs_i);
    // hold_rd is already zeroed when the captured writeback had no write enable
    assign hit_hold  = use_i && (rs_i != '0) && hold_en_i && (hold_rd_i == rs_i);

    // Youngest matching producer wins
    always_comb begin
        sel_o  = FWD_RF;
        data_o = '0;
        if (hit_exmem) begin
            sel_o  = FWD_EXMEM;
            data_o = exmem_result_i;
        end else if (hit_memwb) begin
            sel_o  = FWD_MEMWB;
            data_o = memwb_value_i;
        end else if (hit_hold) begin
            sel_o  = FWD_HOLD;
            data_o = hold_val_i;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding + hazard controller for the 5-stage pipeline. Chooses EX
// operand sources, sequences load-use bubbles and variable-latency load
// freezes, and keeps saturating stall/forward counters.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_RUN   | normal flow; detect load-use and load-wait hazards
//  ST_LU    | bubble inserted last cycle, load now in MEM
//  ST_MWAIT | load in MEM waiting on mem_ready; pipeline frozen
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter bit WB_HOLD = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fwd_hazard_ctrl_if.slave     bus
);

    fsm_state_t        state_q, state_d;
    logic              pc_hold, ifid_hold, idex_bubble, pipe_freeze;
    logic              luh;
    logic              mwait_req;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  fwd_cnt_q;
    logic              hold_en;
    logic [REG_AW-1:0] hold_rd;
    logic [XLEN-1:0]   hold_val;
    logic [1:0]        fwd1_sel, fwd2_sel;

    assign luh = bus.ex_memread && (bus.ex_rd != '0) &&
                 ((bus.id_use1 && (bus.id_rs1 == bus.ex_rd)) ||
                  (bus.id_use2 && (bus.id_rs2 == bus.ex_rd)));

    assign mwait_req = bus.exmem_memread && !bus.mem_ready;

    // Next state and stall controls; everything is forced quiet while in reset
    always_comb begin
        state_d     = state_q;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    // a freeze takes priority; load-use is re-checked once it lifts
                    if (mwait_req) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        pipe_freeze = 1'b1;
                        state_d     = ST_MWAIT;
                    end else if (luh) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = ST_LU;
                    end
                end
                ST_LU: begin
                    if (mwait_req) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        pipe_freeze = 1'b1;
                        state_d     = ST_MWAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MWAIT: begin
                    if (!bus.mem_ready) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        pipe_freeze = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Level-3 bypass: last cycle's writeback, for a regfile without write-through
    generate
        if (WB_HOLD) begin : g_hold
            logic [REG_AW-1:0] hold_rd_q;
            logic [XLEN-1:0]   hold_val_q;
            logic              hold_vld_q;

            // Capture writeback whenever the pipeline advances
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_rd_q  <= '0;
                    hold_val_q <= '0;
                    hold_vld_q <= 1'b0;
                end else if (!pipe_freeze) begin
                    hold_rd_q  <= bus.memwb_wen ? bus.memwb_rd : '0;
                    hold_val_q <= bus.memwb_value;
                    hold_vld_q <= 1'b1;
                end
            end

            assign hold_en  = hold_vld_q;
            assign hold_rd  = hold_rd_q;
            assign hold_val = hold_val_q;
        end else begin : g_no_hold
            assign hold_en  = 1'b0;
            assign hold_rd  = '0;
            assign hold_val = '0;
        end
    endgenerate

    fwd_sel_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd1 (
        .use_i           (bus.ex_use1),
        .rs_i            (bus.ex_rs1),
        .exmem_rd_i      (bus.exmem_rd),
        .exmem_wen_i     (bus.exmem_wen),
        .exmem_memread_i (bus.exmem_memread),
        .exmem_result_i  (bus.exmem_result),
        .memwb_rd_i      (bus.memwb_rd),
        .memwb_wen_i     (bus.memwb_wen),
        .memwb_value_i   (bus.memwb_value),
        .hold_en_i       (hold_en),
        .hold_rd_i       (hold_rd),
        .hold_val_i      (hold_val),
        .sel_o           (fwd1_sel),
        .data_o          (bus.fwd1_data)
    );

    fwd_sel_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd2 (
        .use_i           (bus.ex_use2),
        .rs_i            (bus.ex_rs2),
        .exmem_rd_i      (bus.exmem_rd),
        .exmem_wen_i     (bus.exmem_wen),
        .exmem_memread_i (bus.exmem_memread),
        .exmem_result_i  (bus.exmem_result),
        .memwb_rd_i      (bus.memwb_rd),
        .memwb_wen_i     (bus.memwb_wen),
        .memwb_value_i   (bus.memwb_value),
        .hold_en_i       (hold_en),
        .hold_rd_i       (hold_rd),
        .hold_val_i      (hold_val),
        .sel_o           (fwd2_sel),
        .data_o          (bus.fwd2_data)
    );

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (pc_hold && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (((fwd1_sel != FWD_RF) || (fwd2_sel != FWD_RF)) && (fwd_cnt_q != '1))
                fwd_cnt_q <= fwd_cnt_q + 1'b1;
        end
    end

    assign bus.fwd1_sel    = fwd1_sel;
    assign bus.fwd2_sel    = fwd2_sel;
    assign bus.pc_hold     = pc_hold;
    assign bus.ifid_hold   = ifid_hold;
    assign bus.idex_bubble = idex_bubble;
    assign bus.pipe_freeze = pipe_freeze;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.fwd_cnt     = fwd_cnt_q;

endmodule
